segre_dtlb: RTL
===============

Name: segre_dtlb

Overview:
- Fully associative data TLB between the TL stage and the data cache/store buffer.
- Translates the 32-bit virtual address of a memory op into a 20-bit physical address. Hits resolve in the same cycle.
- On a miss it stalls TL and runs a page-table-walk (PTW) handshake, refills an entry, then lets the op replay.
- Page size 4 KiB: VPN = vaddr[31:12], PPN = PADDR_SIZE-12 = 8 bits, offset = vaddr[11:0].

Parameters:
- VADDR_SIZE, 32, virtual address width (matches segre_pkg).
- PADDR_SIZE, 20, physical address width (matches segre_pkg).
- TLB_NUM_ENTRYS, 4, number of entries; power of two, >= 2.
- PAGE_OFFSET, 12, page offset bits; VPN = VADDR_SIZE-PAGE_OFFSET, PPN = PADDR_SIZE-PAGE_OFFSET.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  TL stage presents a load/store address this cycle
- vaddr_i  in  VADDR_SIZE  virtual address
- vm_en_i  in  1  translation enabled; 0 = bare mode
- flush_i  in  1  invalidate all entries (sfence)
- hit_o  out  1  translation valid this cycle
- miss_o  out  1  stall request to hazard unit (TL stage)
- paddr_o  out  PADDR_SIZE  physical address, valid when hit_o
- fault_o  out  1  one-cycle page-fault pulse
- ptw_req_o  out  1  walk request
- ptw_vpn_o  out  VPN  VPN being walked
- ptw_gnt_i  in  1  PTW accepted request
- ptw_rsp_valid_i  in  1  walk result valid
- ptw_ppn_i  in  PPN  walk result PPN
- ptw_fault_i  in  1  walk result is a fault

Behaviour:
- Reset (async, rst_i=1): all valid bits 0, replacement pointer 0, FSM=IDLE.
  - Outputs at reset: hit_o=0, miss_o=0, fault_o=0, ptw_req_o=0, ptw_vpn_o=0, paddr_o=0.
- Bare mode (vm_en_i=0): with req_i=1, hit_o=1 and paddr_o=vaddr_i[PADDR_SIZE-1:0] combinationally. No lookup, no miss, entries untouched.
- Lookup (vm_en_i=1, FSM=IDLE, req_i=1):
  - Compare VPN against all valid entries combinationally.
  - Single match: hit_o=1, paddr_o={ppn, vaddr_i[11:0]}, miss_o=0. Zero-cycle latency.
  - No match: hit_o=0, miss_o=1 the same cycle. Latch the VPN; FSM goes to REQ on the next edge.
  - Multiple matches cannot occur: fill never duplicates a VPN.
- FSM states: IDLE, REQ, WAIT, FILL, FAULT.
  - IDLE: as above.
  - REQ: ptw_req_o=1, ptw_vpn_o=latched VPN, miss_o=1. On ptw_gnt_i go to WAIT. ptw_req_o is held until the grant.
  - WAIT: miss_o=1. On ptw_rsp_valid_i with ptw_fault_i=0, write entry[repl_ptr] = {valid=1, vpn, ppn} and go to FILL. With ptw_fault_i=1 go to FAULT and do not write.
  - FILL: one cycle. miss_o=1, repl_ptr increments modulo TLB_NUM_ENTRYS, then IDLE. The replayed request hits on the next cycle.
  - FAULT: fault_o=1, miss_o=0, hit_o=0 for exactly one cycle, then IDLE. The TL stage consumes the fault.
- Response arriving in the same cycle as the grant is legal: REQ goes directly to FILL or FAULT.
- Replacement: FIFO/round-robin over entries. The pointer wraps from TLB_NUM_ENTRYS-1 to 0. Invalid entries are not preferred.
- Flush:
  - In IDLE: all valid bits clear on the next edge. A hit in that same cycle is still reported (pre-flush contents).
  - In REQ, WAIT or FILL: valid bits clear. The walk still completes, the resulting fill is discarded (not written), and the FSM returns to IDLE with miss_o kept at 1 until IDLE. The replay then misses and re-walks.
  - Flush during FAULT: fault still pulses.
- req_i dropping during REQ or WAIT does not abort the walk: the fill completes and no hit is reported.
- vm_en_i is sampled only in IDLE.

Optional Feature:
- Macro: SEGRE_DTLB_PERF_CNT_EN.
- Defined: adds outputs perf_hits_o and perf_misses_o, 32 bits each.
  - Hits counts IDLE cycles with req_i && vm_en_i && hit_o.
  - Misses counts IDLE to REQ transitions.
  - Both reset to 0, wrap at 2^32, and clear on flush_i? No: flush does not clear them.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then vm_en_i=0, vaddr_i=0xDEAD_B123 -> hit_o=1, paddr_o=0xDB123, ptw_req_o never asserted.
- vm_en_i=1, vaddr_i=0x0001_2345, PTW grants after 2 cycles and returns ppn=0x7A one cycle later:
  - miss_o=1 from cycle 0.
  - ptw_vpn_o=0x00012.
  - hit_o=1 with paddr_o=0x7A345 on the first IDLE cycle after FILL.
- Fill 5 distinct VPNs 0x1..0x5 -> the 5th evicts VPN 0x1 (pointer wrap). A lookup of VPN 0x1 misses again; VPN 0x2 still hits.
- Walk returns ptw_fault_i=1 -> fault_o high for exactly one cycle, no entry written, re-lookup misses.
- flush_i asserted during WAIT with a valid response the next cycle -> entry not written, replay misses and re-walks; earlier entries also miss.
- PTW response in the same cycle as ptw_gnt_i -> FSM skips WAIT. With SEGRE_DTLB_PERF_CNT_EN, after 3 hits and 1 miss: perf_hits_o=3, perf_misses_o=1.

Source files
------------

// File: rtl/segre_dtlb.sv
// Fully associative data TLB with a page-table-walk handshake on miss.
// Optional perf counters (perf_hits_o/perf_misses_o) when SEGRE_DTLB_PERF_CNT_EN is defined.
module segre_dtlb #(
    parameter int VADDR_SIZE     = 32,
    parameter int PADDR_SIZE     = 20,
    parameter int TLB_NUM_ENTRYS = 4,
    parameter int PAGE_OFFSET    = 12,
    localparam int VPN_W         = VADDR_SIZE - PAGE_OFFSET,
    localparam int PPN_W         = PADDR_SIZE - PAGE_OFFSET
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [VADDR_SIZE-1:0] vaddr_i,
    input  logic                  vm_en_i,
    input  logic                  flush_i,
    output logic                  hit_o,
    output logic                  miss_o,
    output logic [PADDR_SIZE-1:0] paddr_o,
    output logic                  fault_o,
    output logic                  ptw_req_o,
    output logic [VPN_W-1:0]      ptw_vpn_o,
    input  logic                  ptw_gnt_i,
    input  logic                  ptw_rsp_valid_i,
    input  logic [PPN_W-1:0]      ptw_ppn_i,
    input  logic                  ptw_fault_i
`ifdef SEGRE_DTLB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_hits_o,
    output logic [31:0]           perf_misses_o
`endif
);

    localparam int IDX_W = $clog2(TLB_NUM_ENTRYS);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FAULT} state_e;

    state_e                    state_q, state_d;
    logic [TLB_NUM_ENTRYS-1:0] valid_q, valid_d;
    logic [VPN_W-1:0]          tag_q [TLB_NUM_ENTRYS];
    logic [PPN_W-1:0]          ppn_q [TLB_NUM_ENTRYS];
    logic [IDX_W-1:0]          repl_q, repl_d;
    logic [VPN_W-1:0]          vpn_q, vpn_d;
    logic                      drop_q, drop_d;
    logic                      wr_en;
    logic                      match;
    logic [PPN_W-1:0]          match_ppn;
    logic [VPN_W-1:0]          req_vpn;

    assign req_vpn   = vaddr_i[VADDR_SIZE-1:PAGE_OFFSET];
    assign ptw_vpn_o = vpn_q;

    // Fills never duplicate a VPN, so OR-ing the matching PPNs selects the single hit.
    always_comb begin
        match     = 1'b0;
        match_ppn = '0;
        for (int i = 0; i < TLB_NUM_ENTRYS; i++) begin
            if (valid_q[i] && (tag_q[i] == req_vpn)) begin
                match     = 1'b1;
                match_ppn = match_ppn | ppn_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        repl_d    = repl_q;
        vpn_d     = vpn_q;
        drop_d    = drop_q;
        wr_en     = 1'b0;
        hit_o     = 1'b0;
        miss_o    = 1'b0;
        fault_o   = 1'b0;
        ptw_req_o = 1'b0;
        paddr_o   = '0;
        if (flush_i) valid_d = '0;
        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (req_i) begin
                    if (!vm_en_i) begin
                        hit_o   = 1'b1;
                        paddr_o = vaddr_i[PADDR_SIZE-1:0];
                    end else if (match) begin
                        hit_o   = 1'b1;
                        paddr_o = {match_ppn, vaddr_i[PAGE_OFFSET-1:0]};
                    end else begin
                        miss_o  = 1'b1;
                        vpn_d   = req_vpn;
                        state_d = REQ;
                    end
                end
            end
            REQ, WAIT: begin
                miss_o    = 1'b1;
                ptw_req_o = (state_q == REQ);
                if (flush_i) drop_d = 1'b1;
                if (state_q == REQ && ptw_gnt_i && !ptw_rsp_valid_i) begin
                    state_d = WAIT;
                end else if ((state_q == WAIT || ptw_gnt_i) && ptw_rsp_valid_i) begin
                    if (ptw_fault_i) begin
                        state_d = FAULT;
                    end else begin
                        // A flush seen at any point during the walk discards the fill.
                        wr_en   = !(drop_q || flush_i);
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                miss_o  = 1'b1;
                repl_d  = repl_q + IDX_W'(1);
                state_d = IDLE;
            end
            FAULT: begin
                fault_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (wr_en) valid_d[repl_q] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            repl_q  <= '0;
            vpn_q   <= '0;
            drop_q  <= 1'b0;
            for (int i = 0; i < TLB_NUM_ENTRYS; i++) begin
                tag_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            repl_q  <= repl_d;
            vpn_q   <= vpn_d;
            drop_q  <= drop_d;
            if (wr_en) begin
                tag_q[repl_q] <= vpn_q;
                ppn_q[repl_q] <= ptw_ppn_i;
            end
        end
    end

`ifdef SEGRE_DTLB_PERF_CNT_EN
    logic [31:0] hits_q, misses_q;
    assign perf_hits_o   = hits_q;
    assign perf_misses_o = misses_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (state_q == IDLE && req_i && vm_en_i && hit_o) hits_q <= hits_q + 32'd1;
            if (state_q == IDLE && state_d == REQ) misses_q <= misses_q + 32'd1;
        end
    end
`endif

endmodule
